scratch_mem_arbiter: RTL

SCRATCH_MEM_ARBITER -- requirements
Module: scratch_mem_arbiter

---
 rtl/scratch_mem_arbiter_if.sv | 33 +++
 rtl/scratch_mem_arbiter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/scratch_mem_arbiter_if.sv
// Scratch memory arbiter bus: three requesters (histogram, cdf, equalizer)
// on one side, the shared scratch memory port on the other.
// The arbiter connects through the slave modport. The master modport is the
// system side, which drives the requests and the memory read data.
interface scratch_mem_arbiter_if #(
  parameter int DW = 16,
  parameter int AW = 6
);
  logic [2:0]      req;
  logic [2:0]      req_we;
  logic [3*AW-1:0] req_addr;
  logic [3*DW-1:0] req_wdata;
  logic [DW-1:0]   mem_rdata;

  logic [2:0]      gnt;
  logic            mem_en;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [2:0]      rvalid;
  logic [DW-1:0]   rdata;
  logic            busy;

  modport slave (
    input  req, req_we, req_addr, req_wdata, mem_rdata,
    output gnt, mem_en, mem_we, mem_addr, mem_wdata, rvalid, rdata, busy
  );

  modport master (
    output req, req_we, req_addr, req_wdata, mem_rdata,
    input  gnt, mem_en, mem_we, mem_addr, mem_wdata, rvalid, rdata, busy
  );
endinterface

// File: rtl/scratch_mem_arbiter.sv
// Three-way arbiter for the shared histogram scratch memory.
// A grant is held for bursts of up to BURST_MAX cycles when another requester
// is waiting. Every handover passes through a one-cycle RELEASE bubble.
// Optional build macro ARB_ROUND_ROBIN_EN selects round-robin winner search
// instead of fixed priority (histogram > cdf > equalizer).
module scratch_mem_arbiter #(
  parameter int DW        = 16,
  parameter int AW        = 6,
  parameter int BURST_MAX = 64
) (
  input logic                  clk,
  input logic                  reset,
  scratch_mem_arbiter_if.slave bus
);

  localparam int            CW         = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
  localparam logic [CW-1:0] BURST_LAST = CW'(BURST_MAX - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWN     = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    owner_q, owner_d;
  logic [2:0]    gnt_q, gnt_d;
  logic [CW-1:0] burstCnt_q, burstCnt_d;
  logic [2:0]    rvalid_q;

  logic [1:0]    winner;
  logic          ownerReq;
  logic          ownerWe;
  logic          othersReq;
  logic          ownerActive;
  logic          readAccess;

`ifdef ARB_ROUND_ROBIN_EN
  logic [1:0] rrPtr_q, rrPtr_d;

  function automatic logic reqBit(input logic [2:0] r, input logic [1:0] idx);
    case (idx)
      2'd0:    return r[0];
      2'd1:    return r[1];
      default: return r[2];
    endcase
  endfunction

  // The search starts just after the previous owner and wraps modulo 3.
  function automatic logic [1:0] pickWinner(input logic [2:0] r, input logic [1:0] last);
    logic [1:0] cand;
    logic [1:0] win;
    logic       found;
    win   = 2'd0;
    found = 1'b0;
    cand  = (last >= 2'd2) ? 2'd0 : last + 2'd1;
    for (int k = 0; k < 3; k++) begin
      if (!found && reqBit(r, cand)) begin
        win   = cand;
        found = 1'b1;
      end
      cand = (cand >= 2'd2) ? 2'd0 : cand + 2'd1;
    end
    return win;
  endfunction

  // Round-robin winner for the next IDLE grant.
  always_comb begin
    winner = pickWinner(bus.req, rrPtr_q);
  end

  // The pointer remembers the last owner so the search can move past it.
  always_ff @(posedge clk) begin
    if (reset) begin
      rrPtr_q <= 2'd2;
    end else begin
      rrPtr_q <= rrPtr_d;
    end
  end
`else
  // Fixed priority winner: histogram, then cdf, then equalizer.
  always_comb begin
    winner = bus.req[0] ? 2'd0 : (bus.req[1] ? 2'd1 : 2'd2);
  end
`endif

  // Owner qualification and the memory port muxed from the owner's slice.
  always_comb begin
    ownerReq    = |(bus.req & gnt_q);
    ownerWe     = |(bus.req_we & gnt_q);
    othersReq   = |(bus.req & ~gnt_q);
    ownerActive = (state_q == OWN) && ownerReq;
    readAccess  = ownerActive && !ownerWe;

    bus.gnt    = ownerActive ? gnt_q : 3'b000;
    bus.mem_en = ownerActive;
    bus.mem_we = ownerActive && ownerWe;
    bus.busy   = ownerActive;

    case (owner_q)
      2'd1: begin
        bus.mem_addr  = bus.req_addr[1*AW +: AW];
        bus.mem_wdata = bus.req_wdata[1*DW +: DW];
      end
      2'd2: begin
        bus.mem_addr  = bus.req_addr[2*AW +: AW];
        bus.mem_wdata = bus.req_wdata[2*DW +: DW];
      end
      default: begin
        bus.mem_addr  = bus.req_addr[0 +: AW];
        bus.mem_wdata = bus.req_wdata[0 +: DW];
      end
    endcase

    bus.rvalid = rvalid_q;
    bus.rdata  = bus.mem_rdata;
  end

  // Next-state logic: grant from IDLE, burst accounting in OWN, one bubble in RELEASE.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    gnt_d      = gnt_q;
    burstCnt_d = burstCnt_q;
`ifdef ARB_ROUND_ROBIN_EN
    rrPtr_d    = rrPtr_q;
`endif

    case (state_q)
      IDLE: begin
        gnt_d = 3'b000;
        if (|bus.req) begin
          owner_d    = winner;
          gnt_d      = 3'b001 << winner;
          burstCnt_d = '0;
          state_d    = OWN;
`ifdef ARB_ROUND_ROBIN_EN
          rrPtr_d    = winner;
`endif
        end
      end
      OWN: begin
        burstCnt_d = burstCnt_q + CW'(1);
        if (!ownerReq) begin
          gnt_d   = 3'b000;
          state_d = RELEASE;
        end else if (burstCnt_q == BURST_LAST) begin
          burstCnt_d = '0;
          if (othersReq) begin
            gnt_d   = 3'b000;
            state_d = RELEASE;
          end
        end
      end
      RELEASE: begin
        gnt_d   = 3'b000;
        state_d = IDLE;
      end
      default: begin
        gnt_d   = 3'b000;
        state_d = IDLE;
      end
    endcase
  end

  // State registers; a read access flags rvalid to its owner on the next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      owner_q    <= 2'd0;
      gnt_q      <= 3'b000;
      burstCnt_q <= '0;
      rvalid_q   <= 3'b000;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      gnt_q      <= gnt_d;
      burstCnt_q <= burstCnt_d;
      rvalid_q   <= readAccess ? gnt_q : 3'b000;
    end
  end

endmodule
